// File: rtl/makina_pkg.sv
// Shared types and widths for the 16-bit makina core.
// Imported by the fetch stage and its optional performance counters.
package makina_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_FETCH,
        FS_WAIT,
        FS_FULL
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: delivered instructions and flushes.
// Ports: clk, rst_n, fetch_inc_i, flush_inc_i -> fetch_count_o, flush_count_o (16-bit, wrapping).
module fetch_perf_cnt
    import makina_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_inc_i,
    input  logic              flush_inc_i,
    output logic [ADDR_W-1:0] fetch_count_o,
    output logic [ADDR_W-1:0] flush_count_o
);

    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic [ADDR_W-1:0] flush_q, flush_d;

    always_comb begin
        fetch_d = fetch_q;
        flush_d = flush_q;
        if (fetch_inc_i) fetch_d = fetch_q + 16'd1;
        if (flush_inc_i) flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= '0;
            flush_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            flush_q <= flush_d;
        end
    end

    assign fetch_count_o = fetch_q;
    assign flush_count_o = flush_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, decode handoff, redirects.
// Ports: clk, rst_n, pc_write_enabled, branch_target, imem_req_*, imem_rsp_*, instr_*, pc.
// FETCH_PERF_CNT_EN adds fetch_count / flush_count outputs.
module fetch_unit
    import makina_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [ADDR_W-1:0] PC_STEP  = 16'h0001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write_enabled,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [ADDR_W-1:0]  fetch_count,
    output logic [ADDR_W-1:0]  flush_count
`endif
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  infl_q, infl_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    // Set when the outstanding request became stale due to a redirect.
    logic               drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        infl_d  = infl_q;
        data_d  = data_q;
        ipc_d   = ipc_q;
        drop_d  = drop_q;
        unique case (state_q)
            FS_IDLE: state_d = FS_FETCH;
            FS_FETCH: begin
                if (pc_write_enabled) begin
                    pc_d = branch_target;
                    if (imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = FS_WAIT;
                    end
                end else if (imem_req_ready) begin
                    infl_d  = pc_q;
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (pc_write_enabled) begin
                    pc_d = branch_target;
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = FS_FETCH;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = FS_FETCH;
                    end else begin
                        data_d  = imem_rsp_data;
                        ipc_d   = infl_q;
                        pc_d    = pc_q + PC_STEP;
                        state_d = FS_FULL;
                    end
                end
            end
            FS_FULL: begin
                // A same-cycle handshake completes first; leaving FULL then flushes.
                if (pc_write_enabled) begin
                    pc_d    = branch_target;
                    state_d = FS_FETCH;
                end else if (instr_ready) begin
                    state_d = FS_FETCH;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            infl_q  <= '0;
            data_q  <= '0;
            ipc_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            infl_q  <= infl_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
            drop_q  <= drop_d;
        end
    end

    assign imem_req_valid = (state_q == FS_FETCH);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == FS_FULL);
    assign instr_data     = data_q;
    assign instr_pc       = ipc_q;
    assign pc             = pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic flush_inc;

    assign fetch_inc = instr_valid & instr_ready;
    // Discarded response, or held instruction dropped by a redirect.
    assign flush_inc =
        ((state_q == FS_WAIT) & imem_rsp_valid & (pc_write_enabled | drop_q)) |
        ((state_q == FS_FULL) & pc_write_enabled & ~instr_ready);

    fetch_perf_cnt u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_inc_i   (fetch_inc),
        .flush_inc_i   (flush_inc),
        .fetch_count_o (fetch_count),
        .flush_count_o (flush_count)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic
// checked against a stream-level model of the fetched instruction sequence.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write_enabled = 1'b0;
    logic [15:0] branch_target = '0;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [15:0] pc;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] flush_count;
`endif

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_write_enabled (pc_write_enabled),
        .branch_target    (branch_target),
        .imem_req_valid   (imem_req_valid),
        .imem_req_addr    (imem_req_addr),
        .imem_req_ready   (imem_req_ready),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .instr_valid      (instr_valid),
        .instr_data       (instr_data),
        .instr_pc         (instr_pc),
        .instr_ready      (instr_ready),
        .pc               (pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count      (fetch_count),
        .flush_count      (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory model and stream-level reference state.
    bit          m_pend;
    int          m_wait;
    logic [15:0] m_addr;
    logic [15:0] exp_pc;
    logic [15:0] g_key;
    logic [15:0] g_tgt;
    bit          g_req_ready, g_dec_ready, g_redir;
    int          g_lat;
    int          cyc = 0;
    int          since_rst, n_rsp, n_cons, viol, ovl;
    bit          p_hold;
    logic [15:0] p_d, p_pc;
    logic [15:0] q_pc[$], q_data[$], q_epc[$], q_edata[$], q_acc[$];
    int          q_cyc[$];

    task automatic model_clear();
        m_pend = 0; m_wait = 0; m_addr = '0;
        exp_pc = 16'h0000;
        n_rsp = 0; n_cons = 0; since_rst = 0;
        p_hold = 0; viol = 0; ovl = 0;
        q_pc.delete(); q_data.delete(); q_epc.delete();
        q_edata.delete(); q_acc.delete(); q_cyc.delete();
    endtask

    task automatic set_defaults();
        g_req_ready = 1; g_dec_ready = 1; g_redir = 0;
        g_tgt = '0; g_lat = 0; g_key = 16'h1000;
    endtask

    // One clock cycle: called and returns at a falling edge.
    task automatic tick();
        bit acc, cons, redir;
        if (p_hold && (instr_valid !== 1'b1 || instr_data !== p_d || instr_pc !== p_pc))
            viol++;
        if (instr_valid === 1'b1 && imem_req_valid === 1'b1) viol++;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        if (m_pend) begin
            if (imem_req_valid === 1'b1) ovl++;
            if (m_wait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = m_addr + g_key;
                m_pend = 0;
                n_rsp++;
            end else begin
                m_wait--;
            end
        end
        imem_req_ready = g_req_ready;
        instr_ready = g_dec_ready;
        pc_write_enabled = g_redir;
        branch_target = g_tgt;
        acc = (imem_req_valid === 1'b1) && g_req_ready;
        cons = (instr_valid === 1'b1) && g_dec_ready;
        redir = g_redir && since_rst > 0;
        if (acc) begin
            m_pend = 1; m_addr = imem_req_addr; m_wait = g_lat;
            q_acc.push_back(imem_req_addr);
        end
        if (cons) begin
            q_pc.push_back(instr_pc);
            q_data.push_back(instr_data);
            q_epc.push_back(exp_pc);
            q_edata.push_back(exp_pc + g_key);
            q_cyc.push_back(cyc);
            n_cons++;
            exp_pc = exp_pc + 16'd1;
        end
        if (redir) exp_pc = g_tgt;
        p_hold = (instr_valid === 1'b1) && !cons && !redir;
        p_d = instr_data;
        p_pc = instr_pc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        since_rst++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc_write_enabled = 0; imem_req_ready = 0;
        imem_rsp_valid = 0; instr_ready = 0;
        set_defaults();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 16'h0000 ||
            instr_valid !== 1'b0 || instr_data !== 16'h0000 ||
            instr_pc !== 16'h0000 || pc !== 16'h0000) begin
            failures++;
            $display("FAIL reset_vals: got rv=%b ra=%h iv=%b d=%h ipc=%h pc=%h, want 0 0000 0 0000 0000 0000",
                     imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc, pc);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== 16'h0 || flush_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_cnt: got %h/%h want 0000/0000", fetch_count, flush_count);
        end
`endif
        set_defaults();
        model_clear();
        rst_n = 1'b1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_noreq: got %b want 0", imem_req_valid);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000) begin
            failures++;
            $display("FAIL first_req: got v=%b a=%h want 1 0000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        repeat (11) tick();
        checks++;
        if (q_pc.size() < 3) begin
            failures++;
            $display("FAIL seq_count: got %0d want >=3", q_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_pc[i] !== 16'(i) || q_data[i] !== 16'(16'h1000 + i)) begin
                    failures++;
                    $display("FAIL seq_instr%0d: got (%h,%h) want (%h,%h)",
                             i, q_pc[i], q_data[i], 16'(i), 16'(16'h1000 + i));
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (q_cyc[i] - q_cyc[i-1] != 3) begin
                    failures++;
                    $display("FAIL seq_spacing%0d: got %0d want 3", i, q_cyc[i] - q_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
        tick();
        g_redir = 1; g_tgt = 16'hFFFF;
        tick();
        g_redir = 0;
        repeat (14) tick();
        checks++;
        if (q_pc.size() < 2) begin
            failures++;
            $display("FAIL wrap_count: got %0d want >=2", q_pc.size());
        end else begin
            checks++;
            if (q_pc[0] !== 16'hFFFF || q_data[0] !== 16'h0FFF) begin
                failures++;
                $display("FAIL wrap_first: got (%h,%h) want (ffff,0fff)", q_pc[0], q_data[0]);
            end
            checks++;
            if (q_pc[1] !== 16'h0000 || q_data[1] !== 16'h1000) begin
                failures++;
                $display("FAIL wrap_second: got (%h,%h) want (0000,1000)", q_pc[1], q_data[1]);
            end
        end
        k = -1;
        for (int i = 0; i < q_acc.size(); i++)
            if (k < 0 && q_acc[i] === 16'hFFFF) k = i;
        checks++;
        if (k < 0 || k + 1 >= q_acc.size() || q_acc[k+1] !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_nextreq: idx=%0d nacc=%0d want req 0000 after ffff", k, q_acc.size());
        end
    endtask

    task automatic test_redirect_wait();
        bit early;
        logic [15:0] fl0;
        do_reset();
        g_lat = 2;
        tick();
        tick();
        fl0 = '0;
`ifdef FETCH_PERF_CNT_EN
        fl0 = flush_count;
`endif
        g_redir = 1; g_tgt = 16'h0040;
        tick();
        g_redir = 0;
        q_acc.delete();
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (q_acc.size() == 0 && instr_valid === 1'b1) early = 1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL rw_novalid: got instr_valid 1 before redirect fetch, want 0");
        end
        checks++;
        if (q_acc.size() == 0 || q_acc[0] !== 16'h0040) begin
            failures++;
            $display("FAIL rw_nextreq: got %h want 0040", q_acc.size() ? q_acc[0] : 16'hxxxx);
        end
        checks++;
        if (q_pc.size() == 0 || q_pc[0] !== 16'h0040 || q_data[0] !== 16'h1040) begin
            failures++;
            $display("FAIL rw_instr: got n=%0d want (0040,1040)", q_pc.size());
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (flush_count !== fl0 + 16'd1) begin
            failures++;
            $display("FAIL rw_flushcnt: got %h want %h", flush_count, fl0 + 16'd1);
        end
`endif
    endtask

    task automatic test_stall();
        logic [15:0] d0, a0;
        do_reset();
        g_dec_ready = 0;
        for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 16'h1000) begin
            failures++;
            $display("FAIL stall_reach: got v=%b (%h,%h) want 1 (0000,1000)",
                     instr_valid, instr_pc, instr_data);
        end
        d0 = instr_data;
        a0 = instr_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_data !== d0 || instr_pc !== a0 ||
                imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d: got v=%b d=%h pc=%h rv=%b want 1 %h %h 0",
                         i, instr_valid, instr_data, instr_pc, imem_req_valid, d0, a0);
            end
        end
        g_dec_ready = 1;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0001) begin
            failures++;
            $display("FAIL stall_resume: got v=%b rv=%b a=%h want 0 1 0001",
                     instr_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_full_redirect();
        logic [15:0] fc0, fl0;
        do_reset();
        g_dec_ready = 0;
        for (int i = 0; i < 10 && instr_valid !== 1'b1; i++) tick();
        fc0 = '0; fl0 = '0;
`ifdef FETCH_PERF_CNT_EN
        fc0 = fetch_count;
        fl0 = flush_count;
`endif
        g_dec_ready = 1; g_redir = 1; g_tgt = 16'h0100;
        tick();
        g_redir = 0;
        checks++;
        if (q_pc.size() != 1 || q_pc[0] !== 16'h0000) begin
            failures++;
            $display("FAIL fr_consumed: got n=%0d want 1 instr at 0000", q_pc.size());
        end
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0100) begin
            failures++;
            $display("FAIL fr_nextreq: got v=%b rv=%b a=%h want 0 1 0100",
                     instr_valid, imem_req_valid, imem_req_addr);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (fetch_count !== fc0 + 16'd1 || flush_count !== fl0) begin
            failures++;
            $display("FAIL fr_counts: got %h/%h want %h/%h",
                     fetch_count, flush_count, fc0 + 16'd1, fl0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        g_lat = 5;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0000 || imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_async: got pc=%h rv=%b v=%b want 0000 0 0", pc, imem_req_valid, instr_valid);
        end
        @(negedge clk);
        set_defaults();
        model_clear();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        since_rst = 1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000 ||
            instr_valid !== 1'b0 || pc !== 16'h0000) begin
            failures++;
            $display("FAIL rm_post: got rv=%b a=%h v=%b pc=%h want 1 0000 0 0000",
                     imem_req_valid, imem_req_addr, instr_valid, pc);
        end
        repeat (6) tick();
        checks++;
        if (q_pc.size() == 0 || q_pc[0] !== 16'h0000 || q_data[0] !== 16'h1000) begin
            failures++;
            $display("FAIL rm_first: got n=%0d want (0000,1000)", q_pc.size());
        end
    endtask

    task automatic test_random();
        int held;
        do_reset();
        g_key = 16'($urandom);
        for (int i = 0; i < 800; i++) begin
            g_req_ready = ($urandom % 4) != 0;
            g_lat = $urandom_range(0, 2);
            g_dec_ready = ($urandom % 10) < 7;
            g_redir = since_rst > 0 && ($urandom % 12) == 0;
            if ($urandom % 4 == 0) g_tgt = 16'hFFFE + 16'($urandom_range(0, 2));
            else g_tgt = 16'($urandom);
            tick();
        end
        g_redir = 0;
        checks++;
        if (q_pc.size() < 20) begin
            failures++;
            $display("FAIL rnd_progress: got %0d instrs want >=20", q_pc.size());
        end
        for (int i = 0; i < q_pc.size(); i++) begin
            checks++;
            if (q_pc[i] !== q_epc[i] || q_data[i] !== q_edata[i]) begin
                failures++;
                $display("FAIL rnd_instr%0d: got (%h,%h) want (%h,%h)",
                         i, q_pc[i], q_data[i], q_epc[i], q_edata[i]);
            end
        end
        checks++;
        if (viol != 0 || ovl != 0) begin
            failures++;
            $display("FAIL rnd_protocol: got hold_viol=%0d outstanding_viol=%0d want 0 0", viol, ovl);
        end
`ifdef FETCH_PERF_CNT_EN
        held = (instr_valid === 1'b1) ? 1 : 0;
        checks++;
        if (fetch_count !== 16'(n_cons) || flush_count !== 16'(n_rsp - n_cons - held)) begin
            failures++;
            $display("FAIL rnd_counts: got %h/%h want %h/%h",
                     fetch_count, flush_count, 16'(n_cons), 16'(n_rsp - n_cons - held));
        end
`else
        held = 0;
`endif
    endtask

    initial begin
        set_defaults();
        model_clear();
        test_reset();
        test_sequential();
        test_wrap();
        test_redirect_wait();
        test_stall();
        test_full_redirect();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
